// File: rtl/mips_pkg.sv
// Shared MIPS definitions: field widths, opcode/funct encodings and the ID/EX payload.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FN_W     = 6;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LB    = 6'h20;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU   = 6'h24;
  localparam logic [OP_W-1:0] OP_SB    = 6'h28;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FN_W-1:0] FN_JR = 6'h08;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;
  localparam logic [DATA_W-1:0] NOP_INSN = 32'h0;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc;
    logic [OP_W-1:0]     opcode;
    logic [FN_W-1:0]     funct;
    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm_ext;
    logic [TARGET_W-1:0] target;
    logic [REG_AW-1:0]   dest;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } idex_t;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [OP_W-1:0] op);
    return op inside {OP_RTYPE, OP_SB, OP_SW, OP_BEQ, OP_BNE};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two async read ports with write-through bypass, one sync write port.
module decode_regfile
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_rdata,
  output logic [DATA_W-1:0] rt_rdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wb_en && wb_reg != REG_ZERO) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // $0 is forced to zero; a write landing this cycle is forwarded to the reader.
  always_comb begin
    rs_rdata = regs[rs_addr];
    if (rs_addr == REG_ZERO)                 rs_rdata = '0;
    else if (wb_en && wb_reg == rs_addr)     rs_rdata = wb_data;

    rt_rdata = regs[rt_addr];
    if (rt_addr == REG_ZERO)                 rt_rdata = '0;
    else if (wb_en && wb_reg == rt_addr)     rt_rdata = wb_data;
  end

endmodule

// File: rtl/decode.sv
// MIPS DECODE stage: field split, regfile read, control/immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode
  import mips_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   insn_in,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic                insn_valid,
  input  logic                do_branch,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                stall,
  output logic                valid_out,
  output logic [DATA_W-1:0]   pc_out,
  output logic [OP_W-1:0]     opcode_out,
  output logic [FN_W-1:0]     funct_out,
  output logic [SHAMT_W-1:0]  shamt_out,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic [DATA_W-1:0]   imm_ext,
  output logic [TARGET_W-1:0] target_out,
  output logic [REG_AW-1:0]   dest_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write
);

  idex_t idex_q, idex_d;

  logic              hazard;
  logic              issue;
  logic [DATA_W-1:0] insn_d;
  logic [DATA_W-1:0] rs_rdata, rt_rdata;

  logic [OP_W-1:0]   op_in;
  logic [REG_AW-1:0] rs_in, rt_in;

  logic [OP_W-1:0]    op;
  logic [REG_AW-1:0]  rs, rt, rd;
  logic [IMM_W-1:0]   imm;

  assign op_in = insn_in[31:26];
  assign rs_in = insn_in[25:21];
  assign rt_in = insn_in[20:16];

  // Load in ID/EX whose destination feeds the instruction now being decoded.
  assign hazard = idex_q.valid && idex_q.mem_read && (idex_q.dest != REG_ZERO) && insn_valid &&
                  ((idex_q.dest == rs_in) || ((idex_q.dest == rt_in) && reads_rt(op_in)));

  assign stall = hazard && !do_branch;
  assign issue = insn_valid && !do_branch && !hazard;

  // A bubble is decoded as the architectural NOP so every payload field comes out zero.
  assign insn_d = issue ? insn_in : NOP_INSN;

  assign op  = insn_d[31:26];
  assign rs  = insn_d[25:21];
  assign rt  = insn_d[20:16];
  assign rd  = insn_d[15:11];
  assign imm = insn_d[IMM_W-1:0];

  decode_regfile u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rs_addr  (rs),
    .rt_addr  (rt),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .rs_rdata (rs_rdata),
    .rt_rdata (rt_rdata)
  );

  always_comb begin
    idex_d         = '0;
    idex_d.valid   = issue;
    idex_d.pc      = issue ? pc_in : '0;
    idex_d.opcode  = op;
    idex_d.funct   = insn_d[5:0];
    idex_d.shamt   = insn_d[10:6];
    idex_d.rs_data = rs_rdata;
    idex_d.rt_data = rt_rdata;
    idex_d.target  = insn_d[TARGET_W-1:0];

    case (op)
      OP_RTYPE: begin
        idex_d.dest      = rd;
        idex_d.reg_write = (insn_d[5:0] != FN_JR);
      end
      OP_LB, OP_LW, OP_LBU: begin
        idex_d.dest      = rt;
        idex_d.reg_write = 1'b1;
        idex_d.mem_read  = 1'b1;
      end
      OP_SB, OP_SW: idex_d.mem_write = 1'b1;
      OP_JAL: begin
        idex_d.dest      = REG_RA;
        idex_d.reg_write = 1'b1;
      end
      OP_J, OP_BEQ, OP_BNE: ;
      default: begin
        if (op >= OP_ADDI && op <= OP_LUI) begin
          idex_d.dest      = rt;
          idex_d.reg_write = 1'b1;
        end
      end
    endcase

    if (idex_d.dest == REG_ZERO) idex_d.reg_write = 1'b0;

    if (op >= OP_ANDI && op <= OP_XORI)
      idex_d.imm_ext = DATA_W'(imm);
    else if (op == OP_LUI)
      idex_d.imm_ext = {imm, {(DATA_W-IMM_W){1'b0}}};
    else
      idex_d.imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  end

  always_ff @(posedge clock) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign valid_out  = idex_q.valid;
  assign pc_out     = idex_q.pc;
  assign opcode_out = idex_q.opcode;
  assign funct_out  = idex_q.funct;
  assign shamt_out  = idex_q.shamt;
  assign rs_data    = idex_q.rs_data;
  assign rt_data    = idex_q.rt_data;
  assign imm_ext    = idex_q.imm_ext;
  assign target_out = idex_q.target;
  assign dest_reg   = idex_q.dest;
  assign reg_write  = idex_q.reg_write;
  assign mem_read   = idex_q.mem_read;
  assign mem_write  = idex_q.mem_write;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the DECODE stage with hand-computed expected values.
module tb_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_in, pc_in;
  logic        insn_valid, do_branch, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall, valid_out;
  logic [31:0] pc_out;
  logic [5:0]  opcode_out, funct_out;
  logic [4:0]  shamt_out;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [25:0] target_out;
  logic [4:0]  dest_reg;
  logic        reg_write, mem_read, mem_write;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  decode dut (
    .clock(clock), .reset(reset), .insn_in(insn_in), .pc_in(pc_in),
    .insn_valid(insn_valid), .do_branch(do_branch),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall(stall), .valid_out(valid_out), .pc_out(pc_out),
    .opcode_out(opcode_out), .funct_out(funct_out), .shamt_out(shamt_out),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .target_out(target_out), .dest_reg(dest_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic v, input logic br);
    insn_in    = insn;
    pc_in      = pc;
    insn_valid = v;
    do_branch  = br;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;
    tick(); tick();
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_pc",    pc_out,         32'h0);
    check("rst_rw",    32'(reg_write), 32'h0);
    check("rst_stall", 32'(stall),     32'h0);

    // addi $8,$0,5
    reset = 1'b0;
    drive(32'h20080005, 32'h100, 1'b1, 1'b0);
    tick();
    check("addi_valid", 32'(valid_out), 32'h1);
    check("addi_pc",    pc_out,         32'h100);
    check("addi_op",    32'(opcode_out), 32'h08);
    check("addi_dest",  32'(dest_reg),  32'h8);
    check("addi_rw",    32'(reg_write), 32'h1);
    check("addi_imm",   imm_ext,        32'h5);
    check("addi_rs",    rs_data,        32'h0);

    drive(32'h3C01FFFF, 32'h104, 1'b1, 1'b0); tick();
    check("lui_imm",  imm_ext,        32'hFFFF0000);
    check("lui_dest", 32'(dest_reg),  32'h1);
    drive(32'h3402FFFF, 32'h108, 1'b1, 1'b0); tick();
    check("ori_imm",  imm_ext,        32'h0000FFFF);
    drive(32'h2003FFFF, 32'h10C, 1'b1, 1'b0); tick();
    check("addi_sext", imm_ext,       32'hFFFFFFFF);

    // add $10,$9,$9 with same-cycle writeback of $9
    wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'hDEADBEEF;
    drive(32'h01295020, 32'h110, 1'b1, 1'b0); tick();
    check("byp_rs",   rs_data,        32'hDEADBEEF);
    check("byp_rt",   rt_data,        32'hDEADBEEF);
    check("add_dest", 32'(dest_reg),  32'hA);
    check("add_funct", 32'(funct_out), 32'h20);

    // $9 now stored; add $11,$9,$0 while writing $0
    wb_reg = 5'd0; wb_data = 32'h1234;
    drive(32'h01205820, 32'h114, 1'b1, 1'b0); tick();
    check("stored_rs", rs_data,       32'hDEADBEEF);
    check("zero_rt",   rt_data,       32'h0);
    wb_en = 1'b0;
    drive(32'h00006020, 32'h118, 1'b1, 1'b0); tick();
    check("zero_rs_after", rs_data,   32'h0);

    // lw $5,0($4) then add $6,$5,$1 -> one-cycle stall
    drive(32'h8C850000, 32'h200, 1'b1, 1'b0); tick();
    check("lw_mr",   32'(mem_read),  32'h1);
    check("lw_dest", 32'(dest_reg),  32'h5);
    drive(32'h00A13020, 32'h204, 1'b1, 1'b0); #1;
    check("lu_stall", 32'(stall), 32'h1);
    tick();
    check("lu_bubble", 32'(valid_out), 32'h0);
    check("lu_bub_rw", 32'(reg_write), 32'h0);
    check("lu_stall_end", 32'(stall),  32'h0);
    tick();
    check("lu_issue_v",  32'(valid_out), 32'h1);
    check("lu_issue_pc", pc_out,         32'h204);
    check("lu_issue_d",  32'(dest_reg),  32'h6);

    // lw $5 then sw $1,0($5) -> stall
    drive(32'h8C850000, 32'h208, 1'b1, 1'b0); tick();
    drive(32'hACA10000, 32'h20C, 1'b1, 1'b0); #1;
    check("sw_stall", 32'(stall), 32'h1);
    tick(); tick();
    check("sw_mw", 32'(mem_write), 32'h1);
    check("sw_rw", 32'(reg_write), 32'h0);

    // lw $5 then beq $1,$5 -> stall through rt
    drive(32'h8C850000, 32'h210, 1'b1, 1'b0); tick();
    drive(32'h10250000, 32'h214, 1'b1, 1'b0); #1;
    check("beq_stall", 32'(stall), 32'h1);
    tick(); tick();

    // lw $5 then addi $6,$1,1 -> no stall
    drive(32'h8C850000, 32'h218, 1'b1, 1'b0); tick();
    drive(32'h20260001, 32'h21C, 1'b1, 1'b0); #1;
    check("addi_nostall", 32'(stall), 32'h0);
    tick();
    check("addi_issued", 32'(valid_out), 32'h1);
    // addi $5,$1,1 after lw $5: rt is a destination, not a source
    drive(32'h8C850000, 32'h220, 1'b1, 1'b0); tick();
    drive(32'h20250001, 32'h224, 1'b1, 1'b0); #1;
    check("addi_rt_nostall", 32'(stall), 32'h0);
    tick();

    // lw $0 then add $6,$0,$0 -> no stall
    drive(32'h8C800000, 32'h228, 1'b1, 1'b0); tick();
    check("lw0_rw", 32'(reg_write), 32'h0);
    drive(32'h00003020, 32'h22C, 1'b1, 1'b0); #1;
    check("lw0_nostall", 32'(stall), 32'h0);
    tick();

    // do_branch overrides a load-use stall
    drive(32'h8C850000, 32'h230, 1'b1, 1'b0); tick();
    drive(32'h00A13020, 32'h234, 1'b1, 1'b1); #1;
    check("br_stall", 32'(stall), 32'h0);
    tick();
    check("br_bubble", 32'(valid_out), 32'h0);
    check("br_pc",     pc_out,         32'h0);

    // insn_valid=0 -> bubble
    drive(32'h20080005, 32'h238, 1'b0, 1'b0); tick();
    check("inv_bubble", 32'(valid_out), 32'h0);

    // reset mid-stream clears outputs and the regfile
    drive(32'h20080005, 32'h300, 1'b1, 1'b0); tick();
    check("pre_rst_v", 32'(valid_out), 32'h1);
    reset = 1'b1;
    wb_en = 1'b1; wb_reg = 5'd10; wb_data = 32'h55;
    tick();
    check("mid_rst_v",    32'(valid_out), 32'h0);
    check("mid_rst_pc",   pc_out,         32'h0);
    check("mid_rst_dest", 32'(dest_reg),  32'h0);
    check("mid_rst_imm",  imm_ext,        32'h0);
    reset = 1'b0; wb_en = 1'b0;
    drive(32'h01295020, 32'h400, 1'b1, 1'b0); tick();
    check("cleared_rs", rs_data,        32'h0);
    check("cleared_v",  32'(valid_out), 32'h1);
    drive(32'h01400000 | 32'h00005820, 32'h404, 1'b1, 1'b0); tick();
    check("rst_blocks_wb", rs_data,     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
